serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder sequencer built around one single-bit full-adder cell.
- Captures operands on a start pulse and feeds the cell one bit per clock, LSB first, holding the carry in a flip-flop.
- Presents the registered N-bit sum and carry-out with a done pulse.
- Used wherever area matters more than latency; it is the control wrapper that time-shares the full-adder datapath.

Parameters:
- N, 4, operand/sum width in bits; legal range 1..32.
- CW, localparam, counter width = $clog2(N+1), not overridable.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  N  operand A, captured on accepted start.
- B  input  N  operand B, captured on accepted start.
- Cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until done deasserts.
- done  output  1  one-cycle pulse; S and Cout valid from this cycle.
- S  output  N  registered sum; holds until the next done.
- Cout  output  1  registered carry-out; holds with S.

Behaviour:
- Reset: synchronous, active-high on clk.
  - At the first rising edge with rst=1: state=IDLE; busy=0, done=0, S=0, Cout=0; internal shift registers, carry FF and bit counter all 0.
  - rst overrides start and any in-flight operation; mid-operation results are discarded and S/Cout are cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 at an edge -> latch A, B into shift registers, carry FF <= Cin, count <= 0, go SHIFT.
  - SHIFT: full adder gets a_sr[0], b_sr[0], carry FF.
    - Its sum bit shifts into the MSB of the sum shift register.
    - carry FF <= cell carry-out; a_sr, b_sr shift right; count++.
    - When count reaches N-1 at an edge, go DONE.
  - DONE: S <= sum shift register, Cout <= carry FF, done=1 for this cycle only, then IDLE.
- Latency: start accepted at edge k; SHIFT occupies cycles k+1..k+N; done=1 in cycle k+N+1.
  - Back-to-back: a new start in the cycle after done is accepted, giving a throughput of one op per N+2 cycles.
- busy=1 in SHIFT and DONE; 0 in IDLE.
- start while busy (SHIFT or DONE) is ignored; A, B, Cin changes during an operation do not affect the result.
- Arithmetic: {Cout,S} = A + B + Cin, exact, mod 2^(N+1); no overflow flag.
- N=1: a single SHIFT cycle, done in cycle k+2.
- S/Cout change only at DONE or reset; never mid-operation.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Extra input port Sub (1 bit), captured with the operands.
  - Sub=1: B is bit-inverted at capture, carry FF <= 1, Cin ignored; result S = A - B mod 2^N, Cout = 1 means no borrow (A >= B unsigned).
  - Sub=0 behaves identically to the macro-undefined build.
- Undefined: no Sub port; add-only.

Decomposition:
- Shared include file serial_adder_defs.vh holds:
  - State encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10).
  - Default width constant (4).
- One natural sub-module: the existing Full_adder cell (ports A, B, Cin, S, Cout), instantiated once as the bit-slice datapath.
- FSM, counter and shift registers stay in serial_adder_ctrl.

Test Plan:
- N=4, A=5, B=3, Cin=0, start at edge 0 -> busy=1 cycles 1..5, done=1 in cycle 5, S=8, Cout=0.
- A=15, B=1, Cin=0 -> S=0, Cout=1; A=15, B=15, Cin=1 -> S=15, Cout=1; S holds between ops.
- Start A=2, B=2; then in SHIFT pulse start again with A=7, B=7 -> second start ignored, S=4, Cout=0, single done pulse.
- rst=1 in second SHIFT cycle -> next cycle busy=0, done=0, S=0, Cout=0; then A=7, B=9, Cin=0 -> S=0, Cout=1.
- Back-to-back: start held high continuously -> done pulses every 6 cycles, each result correct for operands present at acceptance.
- SERIAL_ADD_SUB_EN, Sub=1: A=9, B=4 -> S=5, Cout=1; A=4, B=9 -> S=11, Cout=0; Cin=1 has no effect.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared state encodings and default width for the serial adder
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sa_state_e;

    localparam int SA_DEFAULT_N = 4;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// rtl/serial_adder_ctrl_full_adder.sv - single-bit full-adder cell (module Full_adder)
module Full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial N-bit adder sequencer, optional subtract via SERIAL_ADD_SUB_EN
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int N = SA_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         Sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout
);

    localparam int CW = $clog2(N + 1);

    sa_state_e     state_q, state_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic [N-1:0]  b_sr_q, b_sr_d;
    logic [N-1:0]  sum_sr_q, sum_sr_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  s_q, s_d;
    logic          cout_q, cout_d;

    logic fa_s;
    logic fa_co;
    logic [N-1:0] b_cap;
    logic         c_cap;

    Full_adder u_fa (
        .A    (a_sr_q[0]),
        .B    (b_sr_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_co)
    );

    // Subtraction is A + ~B + 1, so only the captured B and initial carry differ.
`ifdef SERIAL_ADD_SUB_EN
    assign b_cap = Sub ? ~B : B;
    assign c_cap = Sub ? 1'b1 : Cin;
`else
    assign b_cap = B;
    assign c_cap = Cin;
`endif

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = A;
                    b_sr_d  = b_cap;
                    carry_d = c_cap;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_sr_d = (sum_sr_q >> 1) | (N'(fa_s) << (N - 1));
                carry_d  = fa_co;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Results load on entry to DONE so they are already valid while done is high.
                if (cnt_q == CW'(N - 1)) begin
                    s_d     = sum_sr_d;
                    cout_d  = fa_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign S    = s_q;
    assign Cout = cout_q;

endmodule
